imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction/data memory interface: streams a program image in at run time, replacing the file-based preload.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 32-bit words.
- Issues single-cycle word writes (we/a/wd, word-aligned byte address) into the memory array.
- Holds the MIPS core in reset until loading completes.

Parameters:
NWORDS, 64, memory depth in 32-bit words; load stops after this many words.
IDX_W, 6, width of the word index; equals log2(NWORDS).
BIG_ENDIAN, 1, 1: first byte lands in wd[31:24]; 0: first byte lands in wd[7:0].

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins a load from word 0.
byte_in  input  8  stream data.
byte_valid  input  1  byte_in is valid.
byte_last  input  1  qualifies the final byte of the image; sampled with byte_valid.
byte_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  memory write enable, one cycle per word.
mem_a  output  32  byte address, {24'b0, idx, 2'b00} (upper bits zero), always word aligned.
mem_wd  output  32  assembled write word.
cpu_reset  output  1  active-high reset to the core; 1 while not DONE.
done  output  1  load complete.
word_count  output  IDX_W+1  number of words written in the current/last load.

Behaviour:
- State machine: IDLE, LOAD, WRITE, DONE.
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_a=0, mem_wd=0, cpu_reset=1, done=0, word_count=0.
  - Internal byte counter=0, idx=0, assembly register=0.
- IDLE:
  - Waits for start; all outputs hold their reset values.
  - start -> LOAD, with idx=0, byte counter=0, word_count=0, assembly register=0.
- LOAD:
  - byte_ready=1.
  - Transfer occurs only on byte_valid & byte_ready at a rising edge; byte_in is shifted into the assembly register per BIG_ENDIAN.
  - The byte counter increments modulo 4.
  - On the 4th byte, or on any byte with byte_last=1: next state WRITE.
  - A partial word is zero-padded in the not-yet-filled byte lanes.
- WRITE (exactly one cycle):
  - byte_ready=0, mem_we=1, mem_a={idx,2'b00}, mem_wd=assembled word.
  - Next edge: idx+1, word_count+1, byte counter=0, assembly register cleared.
  - If byte_last was seen, or idx==NWORDS-1: go to DONE. Otherwise go to LOAD.
- DONE:
  - done=1, cpu_reset=0, byte_ready=0, mem_we=0.
  - word_count holds its value.
  - start -> LOAD: cpu_reset returns to 1 in the same cycle as leaving DONE, and done drops.
- Latency: write strobe is asserted the cycle after the 4th byte is accepted. Peak throughput is 4 bytes per 5 cycles.
- start received in LOAD or WRITE is ignored.
- byte_valid received in IDLE, WRITE or DONE is not consumed; byte_ready=0 there.
- Overflow: after the NWORDS-th word the loader enters DONE even if byte_last was never seen. Further bytes are not accepted.
- byte_last on byte 1 of a word: that word is written with bytes 2..4 zero, then DONE.
- mem_we never asserts outside WRITE.
- mem_a and mem_wd hold their last values when mem_we=0 (no X).
- Reset mid-load: the outcome is immediate IDLE, partial word discarded, and no write strobe emitted.
- cpu_reset is registered and glitch-free.

Decomposition:
- Shared package, mips_mem_pkg: state encoding (IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, DONE=2'd3), WORD_W=32, BYTE_W=8, NWORDS default.
- One sub-module: byte_packer (assembly register, byte counter, endian lane select, zero-pad, clear). The FSM, index and handshake stay in imem_loader.

Test Plan:
- Reset then start, 8 bytes 12 34 56 78 9A BC DE F0 (last on F0), BIG_ENDIAN=1:
  - writes 0x12345678 to a=0x00, then 0x9ABCDEF0 to a=0x04;
  - word_count=2, done=1, cpu_reset=0.
- Same stream with BIG_ENDIAN=0 -> words 0x78563412 at 0x00 and 0xF0DEBC9A at 0x04.
- 5 bytes AA BB CC DD EE (last on EE), BIG_ENDIAN=1 -> 0xAABBCCDD at 0x00, 0xEE000000 at 0x04, word_count=2.
- 260 bytes, never asserting last, NWORDS=64:
  - 64 writes, final write at a=0xFC, then DONE;
  - byte_ready=0 afterwards and remaining bytes not consumed.
- Random byte_valid gaps, with reset_n pulsed low after 6 accepted bytes:
  - outputs go to reset values asynchronously;
  - only 1 write has occurred (a=0x00);
  - restart reloads from a=0x00.
- Pulse start in DONE -> cpu_reset=1 and done=0 in the same cycle; word_count clears to 0; reload overwrites from a=0x00.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the instruction/data memory loader path:
//   - loader FSM state encoding
//   - word / byte widths and default memory depth
//   - byte-lane selection helper used by the byte packer
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;
    localparam int NWORDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Byte lane (0 = bits [7:0]) that the cnt-th byte of a word occupies.
    // Big-endian puts the first byte in the most significant lane.
    function automatic logic [1:0] lane_sel(input logic [1:0] cnt,
                                            input logic       big_endian);
        logic [1:0] lane;
        if (big_endian) begin
            lane = 2'd3 - cnt;
        end else begin
            lane = cnt;
        end
        return lane;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Assembles a byte stream into 32-bit words. Each accepted byte is placed in
// its endian-dependent lane; lanes not yet filled stay zero, so a partial word
// is naturally zero-padded.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   clear      in   synchronous clear of assembly register and byte counter
//   accept     in   a byte is transferred this cycle
//   byte_in    in   8-bit stream data
//   byte_cnt   out  number of bytes already held (0..3)
//   word_next  out  assembly register value including the byte being accepted
// -----------------------------------------------------------------------------
module byte_packer
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [1:0]        byte_cnt,
    output logic [WORD_W-1:0] word_next
);

    logic [WORD_W-1:0] word_r;
    logic [1:0]        cnt_r;
    logic [1:0]        lane_s;

    // Merge the incoming byte into its lane of the current assembly word.
    always_comb begin
        lane_s    = lane_sel(cnt_r, BIG_ENDIAN);
        word_next = word_r;
        if (accept) begin
            word_next[{lane_s, 3'b000} +: BYTE_W] = byte_in;
        end else begin
            word_next = word_r;
        end
    end

    // Assembly register and byte counter (counter wraps modulo 4).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_r <= {WORD_W{1'b0}};
            cnt_r  <= 2'd0;
        end else if (clear) begin
            word_r <= {WORD_W{1'b0}};
            cnt_r  <= 2'd0;
        end else if (accept) begin
            word_r <= word_next;
            cnt_r  <= cnt_r + 2'd1;
        end else begin
            word_r <= word_r;
            cnt_r  <= cnt_r;
        end
    end

    assign byte_cnt = cnt_r;

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Run-time program loader for the MIPS instruction/data memory. Receives a
// byte stream over valid/ready, packs it into 32-bit words and writes each
// word with a single-cycle strobe at consecutive word-aligned addresses.
// The core is held in reset (cpu_reset=1) until the load completes.
//
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   start       in   one-cycle pulse, begins a load at word 0 (IDLE/DONE only)
//   byte_in     in   stream data
//   byte_valid  in   byte_in is valid
//   byte_last   in   final byte of the image, qualified by byte_valid
//   byte_ready  out  a byte is accepted this cycle when byte_valid is high
//   mem_we      out  memory write enable, one cycle per word
//   mem_a       out  word-aligned byte address {24'b0, idx, 2'b00}
//   mem_wd      out  assembled write word
//   cpu_reset   out  active-high core reset, low only in DONE
//   done        out  load complete
//   word_count  out  words written in the current/last load
//
// All outputs are registered: each is computed from the next state so it
// lines up with the state it describes, with no combinational glitches.
// -----------------------------------------------------------------------------
module imem_loader
    import mips_mem_pkg::*;
#(
    parameter int NWORDS     = NWORDS_DEFAULT,
    parameter int IDX_W      = 6,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [31:0]       mem_a,
    output logic [31:0]       mem_wd,
    output logic              cpu_reset,
    output logic              done,
    output logic [IDX_W:0]    word_count
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NWORDS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W:0]   WC_ONE  = (IDX_W + 1)'(1);

    state_e            state_r;
    state_e            state_s;

    logic [IDX_W-1:0]  idx_r;
    logic [IDX_W:0]    word_count_r;
    logic              last_seen_r;

    logic              byte_ready_r;
    logic              mem_we_r;
    logic [WORD_W-1:0] mem_a_r;
    logic [WORD_W-1:0] mem_wd_r;
    logic              cpu_reset_r;
    logic              done_r;

    logic              accept_s;
    logic              word_end_s;
    logic              start_load_s;
    logic              clear_s;
    logic [1:0]        byte_cnt_s;
    logic [WORD_W-1:0] word_next_s;

    // Handshake and word-boundary decode.
    always_comb begin
        accept_s     = byte_valid & byte_ready_r & (state_r == ST_LOAD);
        word_end_s   = accept_s & ((byte_cnt_s == 2'd3) | byte_last);
        start_load_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE));
        // Packer is cleared when a load begins and in the write cycle, so the
        // next word always starts from an all-zero (zero-padded) register.
        clear_s      = start_load_s | (state_r == ST_WRITE);
    end

    byte_packer #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_byte_packer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear_s),
        .accept    (accept_s),
        .byte_in   (byte_in),
        .byte_cnt  (byte_cnt_s),
        .word_next (word_next_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (word_end_s) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                // Overflow ends the load even if byte_last never arrived.
                if (last_seen_r || (idx_r == IDX_MAX)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Word index, word counter and end-of-image flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_r        <= {IDX_W{1'b0}};
            word_count_r <= {(IDX_W + 1){1'b0}};
            last_seen_r  <= 1'b0;
        end else if (start_load_s) begin
            idx_r        <= {IDX_W{1'b0}};
            word_count_r <= {(IDX_W + 1){1'b0}};
            last_seen_r  <= 1'b0;
        end else if (state_r == ST_WRITE) begin
            idx_r        <= idx_r + IDX_ONE;
            word_count_r <= word_count_r + WC_ONE;
            last_seen_r  <= last_seen_r;
        end else if (word_end_s) begin
            idx_r        <= idx_r;
            word_count_r <= word_count_r;
            last_seen_r  <= byte_last;
        end else begin
            idx_r        <= idx_r;
            word_count_r <= word_count_r;
            last_seen_r  <= last_seen_r;
        end
    end

    // Registered handshake, write port and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_ready_r <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_a_r      <= {WORD_W{1'b0}};
            mem_wd_r     <= {WORD_W{1'b0}};
            cpu_reset_r  <= 1'b1;
            done_r       <= 1'b0;
        end else begin
            byte_ready_r <= (state_s == ST_LOAD);
            mem_we_r     <= (state_s == ST_WRITE);
            cpu_reset_r  <= (state_s != ST_DONE);
            done_r       <= (state_s == ST_DONE);
            // Address/data are loaded only for a new word and otherwise hold.
            if (word_end_s) begin
                mem_a_r  <= {{(WORD_W - IDX_W - 2){1'b0}}, idx_r, 2'b00};
                mem_wd_r <= word_next_s;
            end else begin
                mem_a_r  <= mem_a_r;
                mem_wd_r <= mem_wd_r;
            end
        end
    end

    assign byte_ready = byte_ready_r;
    assign mem_we     = mem_we_r;
    assign mem_a      = mem_a_r;
    assign mem_wd     = mem_wd_r;
    assign cpu_reset  = cpu_reset_r;
    assign done       = done_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Drives one byte stream into a big-endian and a little-endian loader in
// parallel and checks the words each one writes against hand-computed values.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;

    logic        ready_be, we_be, cpu_reset_be, done_be;
    logic [31:0] a_be, wd_be;
    logic [6:0]  wc_be;
    logic        ready_le, we_le, cpu_reset_le, done_le;
    logic [31:0] a_le, wd_le;
    logic [6:0]  wc_le;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wa_be_log [0:511];
    logic [31:0] wd_be_log [0:511];
    logic [31:0] wa_le_log [0:511];
    logic [31:0] wd_le_log [0:511];
    int          nw_be = 0;
    int          nw_le = 0;

    always #5 clk = ~clk;

    imem_loader #(.NWORDS(64), .IDX_W(6), .BIG_ENDIAN(1'b1)) u_be (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(ready_be),
        .mem_we(we_be), .mem_a(a_be), .mem_wd(wd_be), .cpu_reset(cpu_reset_be),
        .done(done_be), .word_count(wc_be)
    );

    imem_loader #(.NWORDS(64), .IDX_W(6), .BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(ready_le),
        .mem_we(we_le), .mem_a(a_le), .mem_wd(wd_le), .cpu_reset(cpu_reset_le),
        .done(done_le), .word_count(wc_le)
    );

    // Record every write strobe, sampled mid-cycle.
    always @(negedge clk) begin
        if (we_be && nw_be < 512) begin
            wa_be_log[nw_be] = a_be;
            wd_be_log[nw_be] = wd_be;
            nw_be = nw_be + 1;
        end
        if (we_le && nw_le < 512) begin
            wa_le_log[nw_le] = a_le;
            wd_le_log[nw_le] = wd_le;
            nw_le = nw_le + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int g);
        repeat (g) begin
            @(posedge clk); #1;
        end
    endtask

    // Present one byte and hold it until the loader takes it (bounded).
    task automatic send_byte(input logic [7:0] b, input logic last);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = last;
        @(negedge clk);
        while (!ready_be && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_be) begin
            chk("byte_accept_timeout", 32'(ready_be), 32'd1);
        end
        @(posedge clk); #1;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_be && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", 32'(done_be), 32'd1);
    endtask

    typedef struct {
        int          n;
        logic [63:0] data;
        logic [63:0] be;
        logic [63:0] le;
        int          nw;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int          b0, l0, bad;
        logic [63:0] d, wbe, wle;
        logic        rdy_seen;
        logic [7:0]  bv;

        tbl[0] = '{n: 8, data: 64'h12345678_9ABCDEF0, be: 64'h12345678_9ABCDEF0, le: 64'h78563412_F0DEBC9A, nw: 2};
        tbl[1] = '{n: 5, data: 64'hAABBCCDD_EE000000, be: 64'hAABBCCDD_EE000000, le: 64'hDDCCBBAA_000000EE, nw: 2};
        tbl[2] = '{n: 1, data: 64'h5A000000_00000000, be: 64'h5A000000_00000000, le: 64'h0000005A_00000000, nw: 1};
        tbl[3] = '{n: 3, data: 64'h01020300_00000000, be: 64'h01020300_00000000, le: 64'h00030201_00000000, nw: 1};
        tbl[4] = '{n: 4, data: 64'hDEADBEEF_00000000, be: 64'hDEADBEEF_00000000, le: 64'hEFBEADDE_00000000, nw: 1};

        reset_n    = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",     32'(ready_be),     32'd0);
        chk("rst_we",        32'(we_be),        32'd0);
        chk("rst_a",         a_be,              32'd0);
        chk("rst_wd",        wd_be,             32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset_be), 32'd1);
        chk("rst_done",      32'(done_be),      32'd0);
        chk("rst_wcount",    32'(wc_be),        32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Idle: a valid byte without start is not consumed.
        byte_valid = 1'b1;
        idle_cycles(3);
        @(negedge clk);
        chk("idle_ready", 32'(ready_be), 32'd0);
        chk("idle_no_write", 32'(nw_be), 32'd0);
        byte_valid = 1'b0;

        // Table-driven streams, last byte flagged.
        for (int c = 0; c < 5; c++) begin
            b0 = nw_be;
            l0 = nw_le;
            d  = tbl[c].data;
            wbe = tbl[c].be;
            wle = tbl[c].le;
            pulse_start();
            for (int k = 0; k < tbl[c].n; k++) begin
                send_byte(d[63 - 8 * k -: 8], k == tbl[c].n - 1);
            end
            wait_done();
            chk($sformatf("c%0d_nwrites_be", c), 32'(nw_be - b0), 32'(tbl[c].nw));
            chk($sformatf("c%0d_nwrites_le", c), 32'(nw_le - l0), 32'(tbl[c].nw));
            for (int w = 0; w < tbl[c].nw; w++) begin
                chk($sformatf("c%0d_w%0d_addr", c, w), wa_be_log[b0 + w], 32'(4 * w));
                chk($sformatf("c%0d_w%0d_be", c, w), wd_be_log[b0 + w], wbe[63 - 32 * w -: 32]);
                chk($sformatf("c%0d_w%0d_le", c, w), wd_le_log[l0 + w], wle[63 - 32 * w -: 32]);
            end
            chk($sformatf("c%0d_wcount", c),    32'(wc_be),        32'(tbl[c].nw));
            chk($sformatf("c%0d_wcount_le", c), 32'(wc_le),        32'(tbl[c].nw));
            chk($sformatf("c%0d_cpu_reset", c), 32'(cpu_reset_be), 32'd0);
            chk($sformatf("c%0d_done_le", c),   32'(done_le),      32'd1);
            chk($sformatf("c%0d_cpurst_le", c), 32'(cpu_reset_le), 32'd0);
        end

        // Overflow: 256 bytes with no last flag fill all 64 words.
        b0 = nw_be;
        l0 = nw_le;
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1'b0);
        end
        wait_done();
        chk("ovf_nwrites", 32'(nw_be - b0), 32'd64);
        bad = 0;
        for (int w = 0; w < 64; w++) begin
            if (wa_be_log[b0 + w] !== 32'(4 * w)) bad++;
        end
        chk("ovf_addr_seq_errors", 32'(bad), 32'd0);
        chk("ovf_last_addr", wa_be_log[b0 + 63], 32'h0000_00FC);
        chk("ovf_last_be",   wd_be_log[b0 + 63], 32'hFCFD_FEFF);
        chk("ovf_last_le",   wd_le_log[l0 + 63], 32'hFFFE_FDFC);
        chk("ovf_wcount",    32'(wc_be),         32'd64);
        rdy_seen   = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rdy_seen = rdy_seen | ready_be | ready_le;
        end
        byte_valid = 1'b0;
        @(posedge clk); #1;
        chk("ovf_ready_stays_low", 32'(rdy_seen), 32'd0);
        chk("ovf_no_more_writes", 32'(nw_be - b0), 32'd64);

        // Reset mid-load with random gaps after 6 accepted bytes.
        b0 = nw_be;
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            bv = 8'(8'h11 * (k + 1));
            idle_cycles($urandom_range(0, 3));
            send_byte(bv, 1'b0);
            if (k == 3) begin
                @(negedge clk);
                chk("lat_we_after_4th", 32'(we_be),    32'd1);
                chk("lat_a_after_4th",  a_be,          32'd0);
                chk("lat_ready_write",  32'(ready_be), 32'd0);
            end
        end
        reset_n = 1'b0;
        #1;
        chk("amid_ready",     32'(ready_be),     32'd0);
        chk("amid_we",        32'(we_be),        32'd0);
        chk("amid_a",         a_be,              32'd0);
        chk("amid_wd",        wd_be,             32'd0);
        chk("amid_cpu_reset", 32'(cpu_reset_be), 32'd1);
        chk("amid_wcount",    32'(wc_be),        32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle_cycles(3);
        chk("amid_nwrites", 32'(nw_be - b0), 32'd1);
        chk("amid_w0_addr", wa_be_log[b0], 32'd0);
        chk("amid_w0_data", wd_be_log[b0], 32'h1122_3344);
        b0 = nw_be;
        pulse_start();
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h99, 1'b0);
        send_byte(8'hAA, 1'b1);
        wait_done();
        chk("reload_nwrites", 32'(nw_be - b0), 32'd1);
        chk("reload_addr",    wa_be_log[b0],   32'd0);
        chk("reload_data",    wd_be_log[b0],   32'h7788_99AA);

        // Start from DONE: core reset and done change with the state.
        b0 = nw_be;
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk("dstart_done_before", 32'(done_be), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("dstart_cpu_reset", 32'(cpu_reset_be), 32'd1);
        chk("dstart_done",      32'(done_be),      32'd0);
        chk("dstart_wcount",    32'(wc_be),        32'd0);
        chk("dstart_ready",     32'(ready_be),     32'd1);
        @(posedge clk); #1;
        send_byte(8'hCA, 1'b0);
        send_byte(8'hFE, 1'b0);
        send_byte(8'hBA, 1'b0);
        send_byte(8'hBE, 1'b1);
        wait_done();
        chk("dstart_nwrites", 32'(nw_be - b0), 32'd1);
        chk("dstart_addr",    wa_be_log[b0],   32'd0);
        chk("dstart_data",    wd_be_log[b0],   32'hCAFE_BABE);
        chk("dstart_wcount1", 32'(wc_be),      32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
